// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : control_sequencer
//  Purpose  : Microcode sequencer for the bus-based core. Accepts one RV32
//             instruction word over a valid/ready handshake, owns the one-hot
//             step counter and drives the register-file / ALU / immediate bus
//             strobes for OP, OP-IMM, LUI and (optionally) BRANCH.
//  Ports    : clk, reset_n (async assert, active low)
//             instr_valid / instr_ready / instr   - fetch handshake
//             alu_flag                            - branch compare result
//             step, imm, register_index           - sequencing / bus values
//             register_read_enable/_write_enable  - register-file strobes
//             alu_store_1/_2, alu_broadcast, imm_EN, alu_op - ALU/bus strobes
//             branch_taken, pc_load, done, illegal, busy   - status
//  Config   : define CTRL_BRANCH_EN to support BRANCH; otherwise BRANCH
//             traps as illegal and branch_taken / pc_load are tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module control_sequencer #(
    parameter int XLEN       = 32,
    parameter int REG_RD_LAT = 1,
    parameter int STEPS      = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [31:0]      instr,
    input  logic             alu_flag,
    output logic [STEPS-1:0] step,
    output logic [XLEN-1:0]  imm,
    output logic [4:0]       register_index,
    output logic             register_read_enable,
    output logic             register_write_enable,
    output logic             alu_store_1,
    output logic             alu_store_2,
    output logic             alu_broadcast,
    output logic             imm_EN,
    output logic [3:0]       alu_op,
    output logic             branch_taken,
    output logic             pc_load,
    output logic             done,
    output logic             illegal,
    output logic             busy
);

    localparam logic [6:0] C_OPC_OP     = 7'b0110011;
    localparam logic [6:0] C_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] C_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] C_OPC_BRANCH = 7'b1100011;
    // Wait-counter value marking the final cycle of a register read step.
    localparam logic [2:0] C_LAST_CNT   = 3'(REG_RD_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_TRAP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nx;
    logic [STEPS-1:0]   r_step;
    logic [STEPS-1:0]   w_step_nx;
    logic [2:0]         r_cnt;
    logic [2:0]         w_cnt_nx;
    logic [6:0]         r_opcode;
    logic [4:0]         r_rd;
    logic [4:0]         r_rs1;
    logic [4:0]         r_rs2;
    logic [3:0]         r_alu_op;
    logic [XLEN-1:0]    r_imm;

    logic [6:0]         w_opc;
    logic               w_legal;
    logic               w_accept;
    logic signed [31:0] w_imm32;
    logic [XLEN-1:0]    w_imm_nx;
    logic               w_is_opimm;
    logic               w_is_lui;
    logic               w_is_br;
    logic               w_read_step;
    logic               w_rd_final;
    logic               w_last_step;

    // ------------------------------------------------------------------
    // Decode of the word offered by fetch (used only on the accept cycle)
    // ------------------------------------------------------------------
    assign w_opc    = instr[6:0];
    assign w_accept = (r_state == S_IDLE) && instr_valid;

`ifdef CTRL_BRANCH_EN
    assign w_legal = (w_opc == C_OPC_OP) || (w_opc == C_OPC_OP_IMM) ||
                     (w_opc == C_OPC_LUI) || (w_opc == C_OPC_BRANCH);
    assign w_is_br = (r_opcode == C_OPC_BRANCH);
`else
    assign w_legal = (w_opc == C_OPC_OP) || (w_opc == C_OPC_OP_IMM) ||
                     (w_opc == C_OPC_LUI);
    assign w_is_br = 1'b0;
    logic w_unused_alu_flag;
    assign w_unused_alu_flag = alu_flag;
`endif

    // Immediate is formed once at accept and held, so the bus value is
    // stable for the whole instruction and beyond until the next accept.
    always_comb begin
        w_imm32 = 32'sd0;
        case (w_opc)
            C_OPC_OP_IMM: w_imm32 = {{20{instr[31]}}, instr[31:20]};
            C_OPC_LUI:    w_imm32 = {instr[31:12], 12'b0};
`ifdef CTRL_BRANCH_EN
            C_OPC_BRANCH: w_imm32 = {{20{instr[31]}}, instr[7], instr[30:25],
                                     instr[11:8], 1'b0};
`endif
            default:      w_imm32 = 32'sd0;
        endcase
    end

    // Size cast of a signed value sign-extends to XLEN.
    assign w_imm_nx = XLEN'(w_imm32);

    // ------------------------------------------------------------------
    // Step bookkeeping for the latched instruction
    // ------------------------------------------------------------------
    assign w_is_opimm  = (r_opcode == C_OPC_OP_IMM);
    assign w_is_lui    = (r_opcode == C_OPC_LUI);
    assign w_read_step = !w_is_lui && (r_step[0] || (r_step[1] && !w_is_opimm));
    assign w_rd_final  = (r_cnt == C_LAST_CNT);
    assign w_last_step = w_is_lui ? r_step[0] : r_step[2];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_step   <= '0;
            r_cnt    <= 3'd0;
            r_opcode <= 7'd0;
            r_rd     <= 5'd0;
            r_rs1    <= 5'd0;
            r_rs2    <= 5'd0;
            r_alu_op <= 4'd0;
            r_imm    <= '0;
        end else begin
            r_state <= w_state_nx;
            r_step  <= w_step_nx;
            r_cnt   <= w_cnt_nx;
            if (w_accept) begin
                r_opcode <= instr[6:0];
                r_rd     <= instr[11:7];
                r_rs1    <= instr[19:15];
                r_rs2    <= instr[24:20];
                r_alu_op <= {instr[30], instr[14:12]};
                r_imm    <= w_imm_nx;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nx = r_state;
        w_step_nx  = r_step;
        w_cnt_nx   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (instr_valid) begin
                    if (w_legal) begin
                        w_state_nx = S_EXEC;
                        w_step_nx  = STEPS'(1);
                        w_cnt_nx   = 3'd0;
                    end else begin
                        w_state_nx = S_TRAP;
                    end
                end
            end
            S_EXEC: begin
                if (w_last_step) begin
                    w_state_nx = S_IDLE;
                    w_step_nx  = '0;
                    w_cnt_nx   = 3'd0;
                end else if (w_read_step && !w_rd_final) begin
                    w_cnt_nx = r_cnt + 3'd1;
                end else begin
                    w_step_nx = r_step << 1;
                    w_cnt_nx  = 3'd0;
                end
            end
            S_TRAP:  w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs (decoded from registered state, so async reset clears them
    // immediately)
    // ------------------------------------------------------------------
    assign step   = r_step;
    assign imm    = r_imm;
    assign alu_op = r_alu_op;

    always_comb begin
        instr_ready           = 1'b0;
        register_index        = 5'd0;
        register_read_enable  = 1'b0;
        register_write_enable = 1'b0;
        alu_store_1           = 1'b0;
        alu_store_2           = 1'b0;
        alu_broadcast         = 1'b0;
        imm_EN                = 1'b0;
        branch_taken          = 1'b0;
        pc_load               = 1'b0;
        done                  = 1'b0;
        illegal               = 1'b0;
        busy                  = 1'b0;
        case (r_state)
            S_IDLE: instr_ready = 1'b1;
            S_TRAP: begin
                illegal = 1'b1;
                busy    = 1'b1;
            end
            S_EXEC: begin
                busy = 1'b1;
                if (w_is_lui) begin
                    imm_EN                = 1'b1;
                    register_index        = r_rd;
                    register_write_enable = 1'b1;
                    done                  = 1'b1;
                end else if (r_step[0]) begin
                    register_index       = r_rs1;
                    register_read_enable = 1'b1;
                    alu_store_1          = w_rd_final;
                end else if (r_step[1]) begin
                    if (w_is_opimm) begin
                        imm_EN      = 1'b1;
                        alu_store_2 = 1'b1;
                    end else begin
                        register_index       = r_rs2;
                        register_read_enable = 1'b1;
                        alu_store_2          = w_rd_final;
                    end
                end else if (r_step[2]) begin
                    alu_broadcast = 1'b1;
                    done          = 1'b1;
                    if (w_is_br) begin
                        // Compare only: nothing is written back.
                        branch_taken = alu_flag;
                        pc_load      = alu_flag;
                    end else begin
                        register_index        = r_rd;
                        register_write_enable = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_control_sequencer
//  Purpose  : Self-checking bench for control_sequencer. Two instances
//             (REG_RD_LAT = 1 and 3) share clock, reset and instruction; each
//             has its own instr_valid. Expected per-cycle output records are
//             queued when an instruction is launched and compared cycle by
//             cycle on the falling edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_control_sequencer;

`ifdef CTRL_BRANCH_EN
    localparam bit C_BR_EN = 1'b1;
`else
    localparam bit C_BR_EN = 1'b0;
`endif

    typedef struct packed {
        logic [4:0]  step;
        logic [31:0] imm;
        logic [4:0]  idx;
        logic        re, we, as1, as2, ab, ien;
        logic [3:0]  op;
        logic        bt, pcl, done, ill, busy, rdy;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] instr;
    logic        alu_flag;
    logic        valid [2];

    logic        rdy_w  [2];
    logic [4:0]  step_w [2];
    logic [31:0] imm_w  [2];
    logic [4:0]  idx_w  [2];
    logic        re_w   [2];
    logic        we_w   [2];
    logic        as1_w  [2];
    logic        as2_w  [2];
    logic        ab_w   [2];
    logic        ien_w  [2];
    logic [3:0]  op_w   [2];
    logic        bt_w   [2];
    logic        pcl_w  [2];
    logic        done_w [2];
    logic        ill_w  [2];
    logic        busy_w [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        control_sequencer #(
            .XLEN       (32),
            .REG_RD_LAT ((g == 0) ? 1 : 3),
            .STEPS      (5)
        ) u_dut (
            .clk                   (clk),
            .reset_n               (reset_n),
            .instr_valid           (valid[g]),
            .instr_ready           (rdy_w[g]),
            .instr                 (instr),
            .alu_flag              (alu_flag),
            .step                  (step_w[g]),
            .imm                   (imm_w[g]),
            .register_index        (idx_w[g]),
            .register_read_enable  (re_w[g]),
            .register_write_enable (we_w[g]),
            .alu_store_1           (as1_w[g]),
            .alu_store_2           (as2_w[g]),
            .alu_broadcast         (ab_w[g]),
            .imm_EN                (ien_w[g]),
            .alu_op                (op_w[g]),
            .branch_taken          (bt_w[g]),
            .pc_load               (pcl_w[g]),
            .done                  (done_w[g]),
            .illegal               (ill_w[g]),
            .busy                  (busy_w[g])
        );
    end

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    obs_t        expq[$];
    logic [31:0] p_imm [2];
    logic [3:0]  p_op  [2];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic obs_t sample(input int d);
        obs_t o;
        o.step = step_w[d]; o.imm = imm_w[d]; o.idx = idx_w[d];
        o.re = re_w[d]; o.we = we_w[d]; o.as1 = as1_w[d]; o.as2 = as2_w[d];
        o.ab = ab_w[d]; o.ien = ien_w[d]; o.op = op_w[d]; o.bt = bt_w[d];
        o.pcl = pcl_w[d]; o.done = done_w[d]; o.ill = ill_w[d];
        o.busy = busy_w[d]; o.rdy = rdy_w[d];
        return o;
    endfunction

    function automatic obs_t idle_rec(input logic [31:0] i, input logic [3:0] op);
        obs_t e = '0;
        e.rdy = 1'b1;
        e.imm = i;
        e.op  = op;
        return e;
    endfunction

    task automatic check(input int d, input string tag);
        obs_t o;
        obs_t e;
        o = sample(d);
        e = expq.pop_front();
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s dut%0d cyc %0d observed=%h expected=%h", tag, d, cyc, o, e);
        end
    endtask

    // Launch one instruction on instance d and compare every cycle from the
    // accept cycle T through the first idle cycle after completion.
    task automatic run(input int d, input string tag, input logic [31:0] ins,
                       input logic flag, input logic [31:0] eimm);
        int         lat;
        obs_t       e;
        obs_t       base;
        logic [6:0] opc;
        logic [3:0] eop;
        lat = (d == 0) ? 1 : 3;
        opc = ins[6:0];
        eop = {ins[30], ins[14:12]};
        expq.push_back(idle_rec(p_imm[d], p_op[d]));
        base = '0; base.imm = eimm; base.op = eop; base.busy = 1'b1;
        if (opc == 7'h37) begin
            e = base; e.step = 5'd1; e.ien = 1; e.idx = ins[11:7]; e.we = 1; e.done = 1;
            expq.push_back(e);
        end else if (opc == 7'h33 || opc == 7'h13 || (opc == 7'h63 && C_BR_EN)) begin
            for (int c = 0; c < lat; c++) begin
                e = base; e.step = 5'd1; e.idx = ins[19:15]; e.re = 1; e.as1 = (c == lat - 1);
                expq.push_back(e);
            end
            if (opc == 7'h13) begin
                e = base; e.step = 5'd2; e.ien = 1; e.as2 = 1;
                expq.push_back(e);
            end else begin
                for (int c = 0; c < lat; c++) begin
                    e = base; e.step = 5'd2; e.idx = ins[24:20]; e.re = 1; e.as2 = (c == lat - 1);
                    expq.push_back(e);
                end
            end
            e = base; e.step = 5'd4; e.ab = 1; e.done = 1;
            if (opc == 7'h63) begin
                e.bt = flag; e.pcl = flag;
            end else begin
                e.idx = ins[11:7]; e.we = 1;
            end
            expq.push_back(e);
        end else begin
            e = base; e.ill = 1;
            expq.push_back(e);
        end
        expq.push_back(idle_rec(eimm, eop));
        p_imm[d] = eimm;
        p_op[d]  = eop;

        @(posedge clk); #1;
        instr = ins; alu_flag = flag; valid[d] = 1'b1;
        @(negedge clk);
        check(d, {tag, "_T"});
        @(posedge clk); #1;
        valid[d] = 1'b0;
        while (expq.size() > 0) begin
            @(negedge clk);
            check(d, tag);
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        instr    = 32'd0;
        alu_flag = 1'b0;
        valid[0] = 1'b0;
        valid[1] = 1'b0;
        for (int d = 0; d < 2; d++) begin
            p_imm[d] = 32'd0;
            p_op[d]  = 4'd0;
        end

        // Reset held, then released with no valid.
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            expq.push_back(idle_rec(32'd0, 4'd0));
            check(d, "reset_held");
        end
        reset_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            expq.push_back(idle_rec(32'd0, 4'd0));
            check(d, "reset_rel");
        end

        // Latency 1 instance.
        run(0, "op_add",    32'h002081B3, 1'b0, 32'h0000_0000);
        run(0, "addi_100",  32'h06410213, 1'b0, 32'h0000_0064);
        run(0, "lui",       32'h123453B7, 1'b0, 32'h1234_5000);
        run(0, "add_x0",    32'h00208033, 1'b1, 32'h0000_0000);
        run(0, "illegal",   32'h00000073, 1'b0, 32'h0000_0000);

        // Latency 3 instance.
        run(1, "addi_m1",   32'hFFF08293, 1'b0, 32'hFFFF_FFFF);
        run(1, "op_sub",    32'h40C58533, 1'b1, 32'h0000_0000);
        run(1, "lui_neg",   32'h800000B7, 1'b0, 32'h8000_0000);

        // Branch: +8 offset, taken then not taken (traps when unsupported).
        if (C_BR_EN) begin
            run(0, "beq_taken", 32'h00208463, 1'b1, 32'h0000_0008);
            run(0, "beq_nt",    32'h00208463, 1'b0, 32'h0000_0008);
            run(1, "beq_l3",    32'h00208463, 1'b1, 32'h0000_0008);
        end else begin
            run(0, "beq_ill",   32'h00208463, 1'b1, 32'h0000_0000);
        end

        // Reset asserted at T+2 of an OP: outputs clear at once, no done.
        @(posedge clk); #1;
        instr = 32'h002081B3; valid[0] = 1'b1;
        @(posedge clk); #1;
        valid[0] = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            expq.push_back(idle_rec(32'd0, 4'd0));
            check(d, "reset_mid");
        end
        for (int d = 0; d < 2; d++) begin
            p_imm[d] = 32'd0;
            p_op[d]  = 4'd0;
        end
        repeat (2) begin
            @(negedge clk);
            expq.push_back(idle_rec(32'd0, 4'd0));
            check(0, "reset_mid_hold");
        end
        reset_n = 1'b1;
        run(0, "op_after_rst", 32'h002081B3, 1'b0, 32'h0000_0000);
        run(1, "op_after_rst3", 32'h002081B3, 1'b0, 32'h0000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
